r_clk_ctrl: RTL and testbench

Read-clock-domain controller of the asynchronous FIFO. It is the counterpart of the write-side controller and is clocked by r_clk. It performs the following functions:
- holds the binary and Gray read pointers;
- supplies the RAM read address;
- synchronises the write-domain Gray pointer into r_clk;
- generates registered empty, almost-empty and fill-level status for the read client.
The Gray read pointer r_ptr is exported to the write domain for full detection.

---
 rtl/r_clk_ctrl.sv | 73 +++++++
 tb/tb_r_clk_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/r_clk_ctrl.sv
// Read-clock-domain controller of the asynchronous FIFO: read pointers, RAM read
// address, write-pointer synchroniser and registered empty / almost-empty / level status.
module r_clk_ctrl #(
    parameter int unsigned ADDRESS_SIZE        = 4,
    parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
    input  logic                    r_clk,
    input  logic                    rrst_n,
    input  logic                    r_en,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    r_empty,
    output logic                    r_almost_empty,
    output logic [ADDRESS_SIZE:0]   r_level
);

    localparam int unsigned PW = ADDRESS_SIZE + 1;

    logic [PW-1:0] r_bin_q,   r_bin_d;
    logic [PW-1:0] r_ptr_q,   r_ptr_d;
    logic [PW-1:0] rq1_wptr_q;
    logic [PW-1:0] rq2_wptr_q;
    logic          r_empty_q, r_empty_d;
    logic          r_aempty_q, r_aempty_d;
    logic [PW-1:0] r_level_q, r_level_d;

    logic          rd_ok;
    logic [PW-1:0] rq2_wbin;

    // Next-state: reads are accepted only while the registered empty flag is low,
    // so underflow is impossible and needs no error path.
    always_comb begin
        rd_ok      = r_en & ~r_empty_q;
        r_bin_d    = r_bin_q + PW'(rd_ok);
        r_ptr_d    = (r_bin_d >> 1) ^ r_bin_d;
        rq2_wbin   = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            rq2_wbin[i] = ^(rq2_wptr_q >> i);
        end
        r_empty_d  = (r_ptr_d == rq2_wptr_q);
        r_level_d  = rq2_wbin - r_bin_d;
        r_aempty_d = (32'(r_level_d) <= ALMOST_EMPTY_THRESH);
    end

    // Pointer, synchroniser and status registers; all clear asynchronously.
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_bin_q    <= '0;
            r_ptr_q    <= '0;
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
            r_empty_q  <= 1'b1;
            r_aempty_q <= 1'b1;
            r_level_q  <= '0;
        end else begin
            r_bin_q    <= r_bin_d;
            r_ptr_q    <= r_ptr_d;
            rq1_wptr_q <= w_ptr;
            rq2_wptr_q <= rq1_wptr_q;
            r_empty_q  <= r_empty_d;
            r_aempty_q <= r_aempty_d;
            r_level_q  <= r_level_d;
        end
    end

    assign r_ptr          = r_ptr_q;
    assign r_addr         = r_bin_q[ADDRESS_SIZE-1:0];
    assign r_empty        = r_empty_q;
    assign r_almost_empty = r_aempty_q;
    assign r_level        = r_level_q;

endmodule

// File: tb/tb_r_clk_ctrl.sv
// Directed bench for r_clk_ctrl (ADDRESS_SIZE=4, ALMOST_EMPTY_THRESH=2).
module tb_r_clk_ctrl;

    logic       r_clk;
    logic       rrst_n;
    logic       r_en;
    logic [4:0] w_ptr;
    logic [4:0] r_ptr;
    logic [3:0] r_addr;
    logic       r_empty;
    logic       r_almost_empty;
    logic [4:0] r_level;

    int n_vec;
    int n_err;

    r_clk_ctrl #(.ADDRESS_SIZE(4), .ALMOST_EMPTY_THRESH(2)) dut (
        .r_clk          (r_clk),
        .rrst_n         (rrst_n),
        .r_en           (r_en),
        .w_ptr          (w_ptr),
        .r_ptr          (r_ptr),
        .r_addr         (r_addr),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .r_level        (r_level)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [4:0] ptr, input logic [3:0] addr,
                          input logic emp, input logic aemp, input logic [4:0] lvl);
        chk({tag, ".ptr"},   32'(r_ptr),          32'(ptr));
        chk({tag, ".addr"},  32'(r_addr),         32'(addr));
        chk({tag, ".empty"}, 32'(r_empty),        32'(emp));
        chk({tag, ".aempt"}, 32'(r_almost_empty), 32'(aemp));
        chk({tag, ".level"}, 32'(r_level),        32'(lvl));
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    function automatic logic [4:0] g5(input int unsigned b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rrst_n = 1'b1;
        r_en   = 1'b0;
        w_ptr  = 5'b00000;

        // Reset asserted between clock edges takes effect without an edge
        #2 rrst_n = 1'b0;
        #1 chk_st("rst_async", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);
        tick(); tick();
        chk_st("rst_hold", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);
        rrst_n = 1'b1;

        // Single write: visible on the 3rd edge, then one read empties again
        tick();
        w_ptr = 5'b00001;
        tick(); tick();
        chk_st("wr1_e2", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);
        tick();
        chk_st("wr1_e3", 5'b00000, 4'd0, 1'b0, 1'b1, 5'd1);
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk_st("rd1", 5'b00001, 4'd1, 1'b1, 1'b1, 5'd0);

        // Fill (binary 16) and drain with 16 consecutive reads
        rrst_n = 1'b0;
        w_ptr  = 5'b11000;
        tick();
        rrst_n = 1'b1;
        tick(); tick(); tick();
        chk_st("full", 5'b00000, 4'd0, 1'b0, 1'b0, 5'd16);
        r_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk_st($sformatf("drain%0d", k), g5(k), 4'(k), (k == 16), ((16 - k) <= 2), 5'(16 - k));
        end
        tick(); tick();
        chk_st("underrun", 5'b11000, 4'd0, 1'b1, 1'b1, 5'd0);
        r_en = 1'b0;

        // Pointer wrap: binary 20, then 31, then 0
        w_ptr = 5'b11110;
        tick(); tick(); tick();
        chk_st("w20", 5'b11000, 4'd0, 1'b0, 1'b0, 5'd4);
        r_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_st($sformatf("r20_%0d", k), g5(16 + k), 4'(k), (k == 4), ((4 - k) <= 2), 5'(4 - k));
        end
        r_en  = 1'b0;
        chk_st("p20", 5'b11110, 4'd4, 1'b1, 1'b1, 5'd0);
        w_ptr = 5'b10000;
        tick(); tick(); tick();
        chk_st("w31", 5'b11110, 4'd4, 1'b0, 1'b0, 5'd11);
        r_en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 11) r_en = 1'b0;
        end
        chk_st("p31", 5'b10000, 4'd15, 1'b1, 1'b1, 5'd0);
        w_ptr = 5'b00000;
        tick(); tick(); tick();
        chk_st("w0", 5'b10000, 4'd15, 1'b0, 1'b1, 5'd1);
        r_en = 1'b1;
        tick();
        chk_st("p0", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);

        // Underflow: r_en held high while empty
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_st($sformatf("uflow%0d", k), 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);
        end
        r_en = 1'b0;

        // Reset during drain with level 7
        rrst_n = 1'b0;
        w_ptr  = 5'b00100;
        tick();
        rrst_n = 1'b1;
        tick(); tick(); tick();
        chk_st("lvl7", 5'b00000, 4'd0, 1'b0, 1'b0, 5'd7);
        r_en = 1'b1;
        tick();
        chk_st("lvl6", 5'b00001, 4'd1, 1'b0, 1'b0, 5'd6);
        #2 rrst_n = 1'b0;
        w_ptr = 5'b00000;
        #1 chk_st("rst_mid", 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);
        tick(); tick();
        rrst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_st($sformatf("post%0d", k), 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0);
        end
        r_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
